deserializer: RTL

- Downstream neighbour of the serializer: recovers parallel words from the one-bit serial line it drives.
- Single clock domain; the line is sampled once per clk, so there is no oversampling or synchronizer.
- Frames are checked, and each good word is held in a one-entry output register with a valid/ack handshake.
- Feeds the consumer-side logic that reads data_out.

---
 rtl/serial_pkg.sv | 15 +
 rtl/deser_holding_reg.sv | 40 ++++
 rtl/deserializer.sv | 92 +++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: framing levels and the receiver/transmitter state set.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        RECOVER
    } serial_state_e;

    localparam logic SERIAL_IDLE_LEVEL = 1'b1;
    localparam logic START_BIT         = 1'b0;
    localparam logic STOP_BIT          = 1'b1;

endpackage

// File: rtl/deser_holding_reg.sv
// One-entry output register for recovered words: valid/ack handshake and overrun detection.
module deser_holding_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    logic room;

    // A word consumed at the same edge frees the slot for the incoming one.
    assign room = !data_valid || data_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (room) begin
                    data_out   <= word;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: start bit, WIDTH payload bits, stop bit, one bit per clk.
module deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ack,
    output logic             frame_error,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    serial_state_e    state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             load;

    assign load = (state == STOP) && (serial_data_in == STOP_BIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (serial_data_in == START_BIT) begin
                        state <= DATA;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                DATA: begin
                    if (MSB_FIRST)
                        shreg <= {shreg[WIDTH-2:0], serial_data_in};
                    else
                        shreg <= {serial_data_in, shreg[WIDTH-1:1]};
                    if (cnt == CW'(WIDTH - 1))
                        state <= STOP;
                    else
                        cnt <= cnt + CW'(1);
                end
                STOP: begin
                    if (serial_data_in == STOP_BIT) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state       <= RECOVER;
                        frame_error <= 1'b1;
                    end
                end
                RECOVER: begin
                    // A line still low here is the tail of a broken frame, not a start bit.
                    if (serial_data_in == SERIAL_IDLE_LEVEL) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    deser_holding_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .word      (shreg),
        .data_ack  (data_ack),
        .data_out  (data_out),
        .data_valid(data_valid),
        .overrun   (overrun)
    );

endmodule
